// File: rtl/rect_fill_if.sv
// Command and RAM port A bundle for the rectangle-fill engine.
// master = command issuer, slave = fill engine.
interface rect_fill_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_x;
   logic [7:0]  cmd_y;
   logic [7:0]  cmd_w;
   logic [7:0]  cmd_h;
   logic [15:0] cmd_color;
   logic        busy;
   logic        done;
   logic [15:0] address;
   logic [15:0] data;
   logic        wren;

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
      input  cmd_ready, busy, done, address, data, wren
   );

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
      output cmd_ready, busy, done, address, data, wren
   );
endinterface

// File: rtl/rect_fill.sv
// Rectangle-fill engine: clips a command to the framebuffer and
// writes its colour word to every covered word through RAM port A.
module rect_fill #(
   parameter int          FB_WIDTH  = 160,
   parameter int          FB_HEIGHT = 120,
   parameter logic [15:0] FB_BASE   = 16'h0000
) (
   input  logic      clock,
   input  logic      reset,
   rect_fill_if.slave bus
);

   localparam logic [8:0]  W9  = 9'(FB_WIDTH);
   localparam logic [8:0]  H9  = 9'(FB_HEIGHT);
   localparam logic [15:0] W16 = 16'(FB_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      FILL,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  x_q, x_d;
   logic [7:0]  y_q, y_d;
   logic [7:0]  w_q, w_d;
   logic [7:0]  h_q, h_d;
   logic [15:0] color_q, color_d;
   logic [8:0]  xend_q, xend_d;
   logic [8:0]  eh_q, eh_d;
   logic [8:0]  row_q, row_d;
   logic [8:0]  col_q, col_d;
   logic [15:0] rbase_q, rbase_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic        wren_q, wren_d;
   logic        done_q, done_d;

   logic [8:0]  xsum, ysum;
   logic [8:0]  xend, yend;
   logic [8:0]  ew, eh;
   logic [15:0] base0;

   // Clipping and first row address from the latched command
   assign xsum  = {1'b0, x_q} + {1'b0, w_q};
   assign ysum  = {1'b0, y_q} + {1'b0, h_q};
   assign xend  = (xsum > W9) ? W9 : xsum;
   assign yend  = (ysum > H9) ? H9 : ysum;
   assign ew    = ({1'b0, x_q} < W9) ? xend - {1'b0, x_q} : 9'd0;
   assign eh    = ({1'b0, y_q} < H9) ? yend - {1'b0, y_q} : 9'd0;
   assign base0 = FB_BASE + 16'(y_q) * W16;

   // Next-state logic for the controller and its registered outputs
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      w_d     = w_q;
      h_d     = h_q;
      color_d = color_q;
      xend_d  = xend_q;
      eh_d    = eh_q;
      row_d   = row_q;
      col_d   = col_q;
      rbase_d = rbase_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wren_d  = wren_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            wren_d = 1'b0;
            if (bus.cmd_valid) begin
               x_d     = bus.cmd_x;
               y_d     = bus.cmd_y;
               w_d     = bus.cmd_w;
               h_d     = bus.cmd_h;
               color_d = bus.cmd_color;
               state_d = SETUP;
            end
         end
         SETUP: begin
            xend_d  = xend;
            eh_d    = eh;
            row_d   = 9'd0;
            col_d   = {1'b0, x_q};
            rbase_d = base0;
            if (ew == 9'd0 || eh == 9'd0) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               state_d = FILL;
               wren_d  = 1'b1;
               data_d  = color_q;
               addr_d  = base0 + 16'(x_q);
            end
         end
         FILL: begin
            if (col_q + 9'd1 == xend_q) begin
               if (row_q + 9'd1 == eh_q) begin
                  state_d = DONE;
                  wren_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  col_d   = {1'b0, x_q};
                  row_d   = row_q + 9'd1;
                  rbase_d = rbase_q + W16;
                  addr_d  = rbase_q + W16 + 16'(x_q);
               end
            end else begin
               col_d  = col_q + 9'd1;
               addr_d = addr_q + 16'd1;
            end
         end
         DONE: begin
            wren_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
         color_q <= '0;
         xend_q  <= '0;
         eh_q    <= '0;
         row_q   <= '0;
         col_q   <= '0;
         rbase_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wren_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         w_q     <= w_d;
         h_q     <= h_d;
         color_q <= color_d;
         xend_q  <= xend_d;
         eh_q    <= eh_d;
         row_q   <= row_d;
         col_q   <= col_d;
         rbase_q <= rbase_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wren_q  <= wren_d;
         done_q  <= done_d;
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.address   = addr_q;
   assign bus.data      = data_q;
   assign bus.wren      = wren_q;

endmodule

// File: doc/rect_fill.md
Name: rect_fill

Overview:
- Hardware rectangle-fill engine on the CPU side of the video RAM.
- Accepts one fill command at a time: origin, size and 16-bit colour word.
- Writes the colour word into every framebuffer word of the rectangle through RAM port A. The scanout path then displays the result.
- Framebuffer is linear, row-major, one 16-bit word per logical pixel, starting at FB_BASE.

Parameters:
FB_WIDTH, 160, logical pixels per row
FB_HEIGHT, 120, logical rows
FB_BASE, 16'h0000, word address of pixel (0,0)

Ports:
clock  in  1  CPU clock; all logic on rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  engine idle, can accept a command
cmd_x  in  8  left column
cmd_y  in  8  top row
cmd_w  in  8  width in pixels
cmd_h  in  8  height in rows
cmd_color  in  16  word to write
busy  out  1  command in progress (SETUP/FILL/DONE)
done  out  1  one-cycle pulse when a command completes
address  out  16  RAM port A word address
data  out  16  RAM port A write data
wren  out  1  RAM port A write enable

Behaviour:
- Reset (edge with reset=1):
  - State goes to IDLE.
  - wren=0, done=0, busy=0, address=0, data=0.
  - All latched command fields are cleared.
- cmd_ready is 1 exactly when the state is IDLE. It is therefore 1 in the first cycle after reset is released.
- Accept: a command is taken on an edge where cmd_valid && cmd_ready. All cmd_* inputs are sampled only at that edge; later changes are ignored.
- State machine:
  - IDLE -> SETUP on accept.
  - SETUP, one cycle:
    - Clip the rectangle: x_end = min(cmd_x+cmd_w, FB_WIDTH), y_end = min(cmd_y+cmd_h, FB_HEIGHT). Sums are computed at 9 bits, with no wrap.
    - Effective width EW = x_end - cmd_x if cmd_x < FB_WIDTH, else 0. Effective height EH is computed the same way.
    - Load row_base = FB_BASE + cmd_y*FB_WIDTH.
    - If EW=0 or EH=0, go to DONE; otherwise go to FILL.
  - FILL:
    - Each cycle presents one write: wren=1, data=colour, address=row_base+col.
    - col increments from cmd_x to x_end-1.
    - At row end, col resets to cmd_x, row_base += FB_WIDTH, and the row counter increments.
    - After the last word (row EH-1, column x_end-1), go to DONE.
  - DONE, one cycle: done=1, wren=0, then go to IDLE.
- Address arithmetic:
  - row_base is updated incrementally with an adder; no multiplier in the FILL loop.
  - The SETUP computation of cmd_y*FB_WIDTH may be a constant multiply.
  - Addresses are 16-bit modulo 2^16.
- Outputs are registered:
  - wren, address and data change only on clock edges. The first write is visible after the edge ending SETUP.
  - Outside FILL, wren=0. address and data hold their last values; they are don't-care when wren=0.
- Timing for N = EW*EH writes, with accept at edge E0:
  - Writes are visible after edges E1..EN, one per cycle with no gaps.
  - done is visible after E(N+1).
  - cmd_ready returns to 1 after E(N+2).
  - For N=0, done is visible after E1.
- busy = (state != IDLE).
- Reset mid-operation: the next edge with reset=1 aborts the command. wren=0 from that edge on, no done pulse is produced, and the remainder of the rectangle is not written.
- Reset takes priority over accept on the same edge.
- A command held on cmd_valid while busy is not lost. It is accepted at the first edge where cmd_ready=1.

Test Plan:
1. Reset: hold reset 3 cycles with cmd_valid=1 -> wren=0, done=0, busy=0, no accept; cmd_ready=1 the cycle after release.
2. Fill x=2,y=3,w=3,h=2, colour 16'h0F00:
   - Exactly 6 writes at addresses 482,483,484,642,643,644 on consecutive cycles, all data=16'h0F00.
   - done one cycle after the last write (7 edges after accept).
   - cmd_ready back 8 edges after accept.
3. Clip at corner, x=158,y=119,w=5,h=4, colour 16'h00F0 -> exactly 2 writes, addresses 19198 and 19199; done 3 edges after accept.
4. Degenerate commands: w=0 (x=10,y=10,h=5) and, separately, x=200 (w=4,h=4) -> zero wren cycles; done pulse 1 edge after accept; busy for 2 cycles.
5. Reset mid-fill: full-screen fill x=0,y=0,w=255,h=255; assert reset after the 100th write -> wren=0 after that edge, no done. After release, a fill of x=0,y=0,w=1,h=1 writes address 0 and pulses done.
6. Back-to-back with FB_BASE=16'h1000: hold cmd_valid with two commands (1x1 at (0,0), then 2x1 at (5,1)):
   - Second command is accepted exactly at the edge where cmd_ready returns.
   - Writes go to 16'h1000, then 16'h10A5 and 16'h10A6.
   - Two separate done pulses.
